// File: rtl/vram_arbiter.sv
// vram_arbiter: shares the 16 KB video RAM between the video fetch engine and
// the Z80, and produces the CPU T-state clock enable with 48K-style contention.
// Video always wins; contended CPU cycles are held off while fetch owns the RAM.
module vram_arbiter (
    input  logic        clock,
    input  logic        reset,
    input  logic [3:0]  hphase,
    input  logic        fetch,
    input  logic [12:0] videoAddr,
    input  logic [15:0] cpuAddr,
    input  logic        cpuMreq,
    input  logic        cpuIorq,
    input  logic        cpuRd,
    input  logic        cpuWr,
    input  logic [7:0]  cpuDo,
    input  logic [7:0]  ramDo,
    output logic        cpuCe,
    output logic [7:0]  cpuDi,
    output logic [13:0] ramA,
    output logic [7:0]  ramDi,
    output logic        ramWe,
    output logic        ramSel,
    output logic        stall
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ACCESS
    } stateType;

    stateType state;
    stateType nextState;

    logic tick;
    logic contended;
    logic blocked;
    logic vidOwn;
    logic ceRaw;
    logic writeNow;
    logic wrDone;

    // hphase[1] carries no timing information for the arbiter
    logic unusedHphase;
    assign unusedHphase = hphase[1];

    assign tick      = hphase[0];
    assign contended = (cpuMreq && (cpuAddr[15:14] == 2'b01)) || (cpuIorq && !cpuAddr[0]);
    assign blocked   = fetch && (hphase[3] || hphase[2]);
    assign vidOwn    = fetch && hphase[3];

    // Next-state and raw clock-enable decision
    always_comb begin
        nextState = state;
        ceRaw     = 1'b0;
        unique case (state)
            IDLE: begin
                if (tick) begin
                    ceRaw = 1'b1;
                    if (contended) begin
                        if (blocked) begin
                            ceRaw     = 1'b0;
                            nextState = WAIT;
                        end else begin
                            nextState = ACCESS;
                        end
                    end
                end
            end
            WAIT: begin
                if (tick && !blocked) begin
                    ceRaw     = 1'b1;
                    nextState = ACCESS;
                end
            end
            ACCESS: begin
                if (tick) begin
                    ceRaw = 1'b1;
                end
                if (!cpuMreq && !cpuIorq) begin
                    nextState = IDLE;
                end
            end
            default: nextState = IDLE;
        endcase
    end

    assign cpuCe    = ceRaw && !reset;
    assign stall    = tick && !ceRaw && !reset;
    assign ramSel   = (state == ACCESS) && !vidOwn;
    assign ramA     = ramSel ? cpuAddr[13:0] : {1'b0, videoAddr};
    assign ramDi    = cpuDo;
    assign writeNow = ramSel && cpuMreq && cpuWr && !wrDone;

    // State, write strobe and read latch; all on the falling edge like video
    always_ff @(negedge clock) begin
        if (reset) begin
            state  <= IDLE;
            ramWe  <= 1'b0;
            wrDone <= 1'b0;
            cpuDi  <= 8'hFF;
        end else begin
            state  <= nextState;
            ramWe  <= writeNow;
            // one write per ACCESS visit; cleared by any clock outside ACCESS
            wrDone <= (state == ACCESS) && (wrDone || writeNow);
            if (ramSel && cpuMreq && cpuRd) begin
                cpuDi <= ramDo;
            end
        end
    end

endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: directed scenario bench for vram_arbiter.
module tb_vram_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic [3:0]  hph;
    logic        fetch;
    logic [12:0] videoAddr;
    logic [15:0] cpuAddr;
    logic        cpuMreq, cpuIorq, cpuRd, cpuWr;
    logic [7:0]  cpuDo, ramDo;
    logic        cpuCe;
    logic [7:0]  cpuDi;
    logic [13:0] ramA;
    logic [7:0]  ramDi;
    logic        ramWe, ramSel, stall;

    int tests = 0;
    int fails = 0;

    always #5 clock = ~clock;

    vram_arbiter dut (
        .clock(clock), .reset(reset), .hphase(hph), .fetch(fetch),
        .videoAddr(videoAddr), .cpuAddr(cpuAddr), .cpuMreq(cpuMreq),
        .cpuIorq(cpuIorq), .cpuRd(cpuRd), .cpuWr(cpuWr), .cpuDo(cpuDo),
        .ramDo(ramDo), .cpuCe(cpuCe), .cpuDi(cpuDi), .ramA(ramA),
        .ramDi(ramDi), .ramWe(ramWe), .ramSel(ramSel), .stall(stall)
    );

    // Advance one pixel clock; hph models the video horizontal counter
    task automatic nextClk();
        @(negedge clock);
        #1;
        hph = hph + 4'd1;
    endtask

    task automatic busIdle();
        cpuMreq = 1'b0; cpuIorq = 1'b0; cpuRd = 1'b0; cpuWr = 1'b0;
    endtask

    task automatic gotoPhase(input logic [3:0] target);
        for (int i = 0; i < 16; i++) begin
            nextClk();
            if (hph == target) break;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        busIdle();
        for (int i = 0; i < 4; i++) begin
            nextClk();
            #1;
            tests++; if (cpuCe !== 1'b0) begin fails++; $display("FAIL reset_cpuCe hph=%0d got %b want 0", hph, cpuCe); end
            tests++; if (stall !== 1'b0) begin fails++; $display("FAIL reset_stall hph=%0d got %b want 0", hph, stall); end
            tests++; if (ramSel !== 1'b0) begin fails++; $display("FAIL reset_ramSel got %b want 0", ramSel); end
            tests++; if (ramWe !== 1'b0) begin fails++; $display("FAIL reset_ramWe got %b want 0", ramWe); end
            tests++; if (cpuDi !== 8'hFF) begin fails++; $display("FAIL reset_cpuDi got %h want ff", cpuDi); end
        end
        reset = 1'b0;
        #1;
        tests++; if (cpuCe !== 1'b0) begin fails++; $display("FAIL release_even_cpuCe got %b want 0", cpuCe); end
        nextClk();
        #1;
        tests++; if (cpuCe !== 1'b1) begin fails++; $display("FAIL first_cpuCe hph=%0d got %b want 1", hph, cpuCe); end
    endtask

    task automatic test_free_run();
        int pulses = 0;
        fetch = 1'b1;
        busIdle();
        for (int i = 0; i < 32; i++) begin
            nextClk();
            #1;
            if (cpuCe === 1'b1) pulses++;
            tests++; if (cpuCe !== hph[0]) begin fails++; $display("FAIL free_cpuCe hph=%0d got %b want %b", hph, cpuCe, hph[0]); end
            tests++; if (stall !== 1'b0) begin fails++; $display("FAIL free_stall hph=%0d got %b want 0", hph, stall); end
        end
        tests++; if (pulses != 16) begin fails++; $display("FAIL free_pulses got %0d want 16", pulses); end
    endtask

    task automatic test_max_contention();
        fetch = 1'b1;
        busIdle();
        gotoPhase(4'd5);
        cpuMreq = 1'b1; cpuRd = 1'b1; cpuAddr = 16'h4000; ramDo = 8'h3C;
        #1;
        tests++; if (cpuCe !== 1'b0 || stall !== 1'b1) begin fails++; $display("FAIL maxc_first cpuCe=%b stall=%b want 0/1", cpuCe, stall); end
        for (int i = 0; i < 11; i++) begin
            nextClk();
            #1;
            tests++; if (cpuCe !== 1'b0) begin fails++; $display("FAIL maxc_cpuCe hph=%0d got %b want 0", hph, cpuCe); end
            tests++; if (stall !== hph[0]) begin fails++; $display("FAIL maxc_stall hph=%0d got %b want %b", hph, stall, hph[0]); end
            tests++; if (ramSel !== 1'b0) begin fails++; $display("FAIL maxc_ramSel_wait hph=%0d got %b want 0", hph, ramSel); end
        end
        nextClk();
        #1;
        tests++; if (cpuCe !== 1'b1 || stall !== 1'b0) begin fails++; $display("FAIL maxc_grant hph=%0d cpuCe=%b stall=%b want 1/0", hph, cpuCe, stall); end
        nextClk();
        #1;
        tests++; if (ramSel !== 1'b1) begin fails++; $display("FAIL maxc_ramSel got %b want 1", ramSel); end
        tests++; if (ramA !== 14'h0000) begin fails++; $display("FAIL maxc_ramA got %h want 0000", ramA); end
        tests++; if (cpuDi !== 8'hFF) begin fails++; $display("FAIL maxc_cpuDi_early got %h want ff", cpuDi); end
        nextClk();
        #1;
        tests++; if (cpuDi !== 8'h3C) begin fails++; $display("FAIL maxc_cpuDi got %h want 3c", cpuDi); end
        busIdle();
    endtask

    task automatic test_no_fetch();
        fetch = 1'b0;
        busIdle();
        gotoPhase(4'd5);
        cpuMreq = 1'b1; cpuRd = 1'b1; cpuAddr = 16'h4000; ramDo = 8'h5A;
        #1;
        tests++; if (cpuCe !== 1'b1 || stall !== 1'b0) begin fails++; $display("FAIL nofetch_tick cpuCe=%b stall=%b want 1/0", cpuCe, stall); end
        nextClk();
        #1;
        tests++; if (ramSel !== 1'b1 || ramA !== 14'h0000) begin fails++; $display("FAIL nofetch_access ramSel=%b ramA=%h want 1/0000", ramSel, ramA); end
        nextClk();
        #1;
        tests++; if (cpuDi !== 8'h5A) begin fails++; $display("FAIL nofetch_cpuDi got %h want 5a", cpuDi); end
        tests++; if (cpuCe !== 1'b1 || stall !== 1'b0) begin fails++; $display("FAIL nofetch_ce7 cpuCe=%b stall=%b want 1/0", cpuCe, stall); end
        busIdle();
    endtask

    task automatic test_uncontended();
        fetch = 1'b1;
        busIdle();
        gotoPhase(4'd5);
        cpuMreq = 1'b1; cpuRd = 1'b1; cpuAddr = 16'h8000; ramDo = 8'hC3;
        for (int i = 0; i < 11; i++) begin
            if (i > 0) nextClk();
            videoAddr = 13'h1A00 | {9'd0, hph};
            #1;
            tests++; if (cpuCe !== hph[0] || stall !== 1'b0) begin fails++; $display("FAIL unc_ce hph=%0d cpuCe=%b stall=%b", hph, cpuCe, stall); end
            tests++; if (ramSel !== 1'b0) begin fails++; $display("FAIL unc_ramSel hph=%0d got %b want 0", hph, ramSel); end
            tests++; if (ramA !== {1'b0, videoAddr}) begin fails++; $display("FAIL unc_ramA got %h want %h", ramA, {1'b0, videoAddr}); end
        end
        tests++; if (cpuDi !== 8'h5A) begin fails++; $display("FAIL unc_cpuDi_held got %h want 5a", cpuDi); end
        busIdle();
    endtask

    task automatic test_write();
        fetch = 1'b1;
        busIdle();
        gotoPhase(4'd15);
        cpuMreq = 1'b1; cpuWr = 1'b1; cpuAddr = 16'h4001; cpuDo = 8'hA5;
        #1;
        tests++; if (cpuCe !== 1'b0 || stall !== 1'b1) begin fails++; $display("FAIL wr_hold15 cpuCe=%b stall=%b want 0/1", cpuCe, stall); end
        nextClk();
        nextClk();
        #1;
        tests++; if (cpuCe !== 1'b1 || stall !== 1'b0) begin fails++; $display("FAIL wr_grant1 cpuCe=%b stall=%b want 1/0", cpuCe, stall); end
        nextClk();
        #1;
        tests++; if (ramSel !== 1'b1 || ramA !== 14'h0001) begin fails++; $display("FAIL wr_addr ramSel=%b ramA=%h want 1/0001", ramSel, ramA); end
        tests++; if (ramDi !== 8'hA5) begin fails++; $display("FAIL wr_ramDi got %h want a5", ramDi); end
        tests++; if (ramWe !== 1'b0) begin fails++; $display("FAIL wr_we_early got %b want 0", ramWe); end
        nextClk();
        #1;
        tests++; if (ramWe !== 1'b1) begin fails++; $display("FAIL wr_we_pulse got %b want 1", ramWe); end
        for (int i = 0; i < 4; i++) begin
            nextClk();
            #1;
            tests++; if (ramWe !== 1'b0) begin fails++; $display("FAIL wr_we_second hph=%0d got %b want 0", hph, ramWe); end
        end
        busIdle();
    endtask

    task automatic test_io();
        fetch = 1'b1;
        busIdle();
        gotoPhase(4'd1);
        cpuIorq = 1'b1; cpuWr = 1'b1; cpuAddr = 16'h00FE; cpuDo = 8'h55;
        #1;
        tests++; if (cpuCe !== 1'b1) begin fails++; $display("FAIL io_grant got %b want 1", cpuCe); end
        nextClk();
        #1;
        tests++; if (ramSel !== 1'b1 || ramA !== 14'h00FE) begin fails++; $display("FAIL io_access ramSel=%b ramA=%h want 1/00fe", ramSel, ramA); end
        nextClk();
        #1;
        tests++; if (ramWe !== 1'b0) begin fails++; $display("FAIL io_ramWe got %b want 0", ramWe); end
        busIdle();
        gotoPhase(4'd5);
        cpuIorq = 1'b1; cpuRd = 1'b1; cpuAddr = 16'h00FF;
        #1;
        tests++; if (cpuCe !== 1'b1 || stall !== 1'b0) begin fails++; $display("FAIL oddport_ce cpuCe=%b stall=%b want 1/0", cpuCe, stall); end
        nextClk();
        #1;
        tests++; if (ramSel !== 1'b0) begin fails++; $display("FAIL oddport_ramSel got %b want 0", ramSel); end
        busIdle();
    endtask

    task automatic test_reset_wait();
        fetch = 1'b1;
        busIdle();
        gotoPhase(4'd5);
        cpuMreq = 1'b1; cpuRd = 1'b1; cpuAddr = 16'h4000;
        nextClk();
        nextClk();
        #1;
        tests++; if (stall !== 1'b1) begin fails++; $display("FAIL rstw_wait7 stall got %b want 1", stall); end
        nextClk();
        reset = 1'b1;
        #1;
        tests++; if (cpuCe !== 1'b0) begin fails++; $display("FAIL rstw_cpuCe8 got %b want 0", cpuCe); end
        nextClk();
        reset = 1'b0;
        busIdle();
        #1;
        tests++; if (cpuCe !== 1'b1 || stall !== 1'b0) begin fails++; $display("FAIL rstw_ce9 cpuCe=%b stall=%b want 1/0", cpuCe, stall); end
        tests++; if (ramSel !== 1'b0 || cpuDi !== 8'hFF) begin fails++; $display("FAIL rstw_regs ramSel=%b cpuDi=%h want 0/ff", ramSel, cpuDi); end
    endtask

    task automatic test_fetch_fall();
        fetch = 1'b1;
        busIdle();
        gotoPhase(4'd5);
        cpuMreq = 1'b1; cpuRd = 1'b1; cpuAddr = 16'h4000;
        nextClk();
        fetch = 1'b0;
        nextClk();
        #1;
        tests++; if (cpuCe !== 1'b1 || stall !== 1'b0) begin fails++; $display("FAIL ffall_grant cpuCe=%b stall=%b want 1/0", cpuCe, stall); end
        nextClk();
        #1;
        tests++; if (ramSel !== 1'b1) begin fails++; $display("FAIL ffall_ramSel got %b want 1", ramSel); end
        busIdle();
    endtask

    task automatic test_preempt();
        fetch = 1'b1;
        busIdle();
        gotoPhase(4'd1);
        cpuMreq = 1'b1; cpuRd = 1'b1; cpuAddr = 16'h4002; ramDo = 8'h77;
        nextClk();
        #1;
        tests++; if (ramSel !== 1'b1 || ramA !== 14'h0002) begin fails++; $display("FAIL pre_access ramSel=%b ramA=%h want 1/0002", ramSel, ramA); end
        for (int i = 0; i < 5; i++) nextClk();
        for (int i = 0; i < 8; i++) begin
            nextClk();
            ramDo = 8'hEE;
            videoAddr = 13'h0800 | {9'd0, hph};
            #1;
            tests++; if (ramSel !== 1'b0) begin fails++; $display("FAIL pre_ramSel hph=%0d got %b want 0", hph, ramSel); end
            tests++; if (ramA !== {1'b0, videoAddr}) begin fails++; $display("FAIL pre_ramA got %h want %h", ramA, {1'b0, videoAddr}); end
            tests++; if (cpuDi !== 8'h77) begin fails++; $display("FAIL pre_cpuDi hph=%0d got %h want 77", hph, cpuDi); end
            tests++; if (cpuCe !== hph[0] || stall !== 1'b0) begin fails++; $display("FAIL pre_ce hph=%0d cpuCe=%b stall=%b", hph, cpuCe, stall); end
        end
        busIdle();
    endtask

    initial begin
        hph = 4'd0; fetch = 1'b0; videoAddr = '0; cpuAddr = '0;
        cpuDo = '0; ramDo = '0; reset = 1'b1;
        busIdle();
        test_reset();
        test_free_run();
        test_max_contention();
        test_no_fetch();
        test_uncontended();
        test_write();
        test_io();
        test_reset_wait();
        test_fetch_fall();
        test_preempt();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/vram_arbiter.md
# vram_arbiter

Shares the 16 KB video RAM between the video fetch engine and the Z80 CPU, and generates the CPU T-state clock enable with 48K-style contention. It sits between `video` (phase, fetch window and 13-bit fetch address), the CPU bus and the VRAM. CPU accesses to 0x4000–0x7FFF and to even ULA I/O ports are stalled while the video fetch owns the RAM. Video always has priority.

## Interface

Parameters: none.

- `clock`  in  1  pixel clock, 7 MHz. All registers update on the falling edge, matching `video`.
- `reset`  in  1  synchronous, active-high.
- `hphase`  in  4  low 4 bits of the video horizontal counter.
- `fetch`  in  1  video fetch window active (display area).
- `videoAddr`  in  13  video fetch address.
- `cpuAddr`  in  16  CPU address bus.
- `cpuMreq`  in  1  memory request, active-high.
- `cpuIorq`  in  1  I/O request, active-high.
- `cpuRd`  in  1  read strobe, active-high.
- `cpuWr`  in  1  write strobe, active-high.
- `cpuDo`  in  8  CPU write data.
- `ramDo`  in  8  VRAM read data.
- `cpuCe`  out  1  CPU T-state clock enable, one clock wide.
- `cpuDi`  out  8  latched VRAM read data for the CPU.
- `ramA`  out  14  VRAM address.
- `ramDi`  out  8  VRAM write data (`cpuDo` passed through).
- `ramWe`  out  1  VRAM write enable, registered.
- `ramSel`  out  1  VRAM owner: 0 = video, 1 = CPU.
- `stall`  out  1  high on ticks where `cpuCe` is suppressed.

## Operation

**Definitions**
- tick = (hphase[0]==1); one T-state = 2 clocks (3.5 MHz).
- contended = (cpuMreq && cpuAddr[15:14]==2'b01) || (cpuIorq && !cpuAddr[0]).
- blocked = fetch && (hphase[3] || hphase[2]). This blocks hphase 4..15, i.e. 6 of every 8 T-states.
- vidOwn = fetch && hphase[3].

**FSM states:** IDLE, WAIT, ACCESS. Reset → IDLE.
- IDLE, on a tick:
  - contended && blocked → suppress `cpuCe`, go to WAIT.
  - contended && !blocked → assert `cpuCe`, go to ACCESS.
  - otherwise → assert `cpuCe`.
- WAIT, on a tick:
  - blocked → suppress `cpuCe`.
  - else → assert `cpuCe`, go to ACCESS.
- ACCESS:
  - On every tick, assert `cpuCe`.
  - On any clock with !cpuMreq && !cpuIorq → IDLE.
  - A request that becomes contended in the same cycle is evaluated from IDLE at the next tick.
- `cpuCe` is combinational: tick && !(suppress condition). It is never high off-tick.
- `stall` = tick && `cpuCe` suppressed.

**Ownership and address**
- `ramSel` = (state==ACCESS) && !vidOwn. Video preempts a CPU access that overruns into hphase 8..15.
- `ramA` = `ramSel` ? cpuAddr[13:0] : {1'b0, videoAddr}.
- I/O accesses reach ACCESS only for timing. `ramWe` never asserts for I/O.

**Write**
- `ramWe` is registered high for exactly one clock.
- Condition: the clock following the first clock in ACCESS where `ramSel` && cpuMreq && cpuWr.
- Only one write pulse per ACCESS visit.
- `ramDi` = `cpuDo`.

**Read**
- `cpuDi` <= `ramDo` on every clock where `ramSel` && cpuMreq && cpuRd.
- `cpuDi` holds its value otherwise, including during preemption.

**Uncontended access** (ROM, 0x8000+, odd ports): no stall, `ramSel` stays 0.

## Timing

**Reset values:** state IDLE, `ramWe` 0, `cpuDi` 8'hFF, `ramSel` 0, `stall` 0, `cpuCe` 0.

**First `cpuCe` after reset:** the first clock with hphase[0]==1 after `reset` deasserts.

**Contention delay**, by the hphase of the tick at which the contended request is seen (fetch=1):

| hphase | suppressed ticks |
|---|---|
| 5 | 6 |
| 7 | 5 |
| 9 | 4 |
| 11 | 3 |
| 13 | 2 |
| 15 | 1 |
| 1 | 0 |
| 3 | 0 |

- Grant in all of these cases occurs at hphase 1.
- `fetch` falling while in WAIT: grant at the next tick.
- Reset mid-WAIT or mid-ACCESS: IDLE next clock, `ramWe` dropped, `ramSel` 0.
- Latency: `ramA`/`ramSel` are combinational from state; `ramWe` lags by 1 clock; `cpuDi` is valid 1 clock after `ramSel` rises.

## Test plan

- **Free-running clock enable.** Idle bus, fetch=1, 32 clocks → `cpuCe` high exactly at hphase 1,3,5,…,15 (16 pulses); `stall` never high.
- **Maximum contention.** Read at 0x4000 seen at the hphase=5 tick, fetch=1 → `cpuCe` low at 5,7,9,11,13,15; high at hphase 1; `ramSel`=1, `ramA`=0x0000. With `ramDo`=0x3C, `cpuDi`=0x3C one clock later.
- **No fetch, no contention.** Same read with fetch=0 → no suppressed tick; ACCESS entered at hphase 5.
- **Uncontended address.** Read at 0x8000 with fetch=1 at hphase 5 → no stall; `ramSel`=0; `ramA` tracks `videoAddr`.
- **Write.** Write 0xA5 to 0x4001 granted at hphase 1 → one-clock `ramWe`, `ramA`=0x0001, `ramDi`=0xA5. No second pulse while cpuWr stays high.
- **Reset and preemption.**
  - Reset during WAIT → IDLE, `cpuCe` at the next odd hphase.
  - Access held into hphase 8 with fetch=1 → `ramSel`=0 and `ramA`=videoAddr while `cpuDi` is held.
